// File: rtl/combo_reservation_station_pkg.sv
// Shared types for the combo reservation station: instruction enums, entry layout, helpers.
// Optional feature macro: RS_AGE_ORDER_EN adds a per-entry age field.
package combo_reservation_station_pkg;

  localparam int RS_XLEN  = 32;
  localparam int RS_DEPTH = 8;
  localparam int RS_REGW  = 6;
  localparam int RS_IDX_W = $clog2(RS_DEPTH);
  localparam int RS_CNT_W = RS_IDX_W + 1;

  typedef enum logic [3:0] {
    UNKNOWN = 4'd0, ADD, SUB, AND_OP, OR_OP, XOR_OP, SLL, SRL,
    SRA, SLT, SLTU, LUI, AUIPC, JAL, JALR, BRANCH
  } instr_name_e;

  typedef enum logic [1:0] {ST_NONE, ST_BYTE, ST_HALF, ST_WORD} st_type_e;

  typedef struct packed {
    logic [RS_XLEN-1:0] address;
    logic [RS_XLEN-1:0] immediate;
    logic [RS_REGW-1:0] src_1;
    logic [RS_REGW-1:0] src_2;
    logic [RS_REGW-1:0] arn;
    logic [RS_REGW-1:0] rrn;
    logic               jump;
    logic               tag;
    instr_name_e        instr_name;
    st_type_e           st_type;
  } rs_payload_t;

  typedef struct packed {
    logic               valid;
    rs_payload_t        payload;
    logic [RS_XLEN-1:0] op_1;
    logic [RS_XLEN-1:0] op_2;
    logic               rdy_1;
    logic               rdy_2;
`ifdef RS_AGE_ORDER_EN
    logic [RS_IDX_W-1:0] age;
`endif
  } rs_entry_t;

  function automatic logic [RS_CNT_W-1:0] rs_popcount(input logic [RS_DEPTH-1:0] v);
    rs_popcount = '0;
    for (int i = 0; i < RS_DEPTH; i++) rs_popcount = rs_popcount + RS_CNT_W'(v[i]);
  endfunction

endpackage

// File: rtl/combo_reservation_station_rs_select.sv
// Issue picker: one-hot grant among ready entries. Lowest index wins by default;
// with RS_AGE_ORDER_EN the entry with the largest age (oldest) wins.
module combo_reservation_station_rs_select
  import combo_reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            req_i,
`ifdef RS_AGE_ORDER_EN
  input  logic [DEPTH-1:0][IDX_W-1:0] age_i,
`endif
  output logic [DEPTH-1:0]            gnt_o,
  output logic [IDX_W-1:0]            idx_o,
  output logic                        vld_o
);

`ifdef RS_AGE_ORDER_EN
  logic [IDX_W-1:0] best_age;
`endif

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
`ifdef RS_AGE_ORDER_EN
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // ages of live entries are unique, strict compare keeps lowest index on ties anyway
      if (req_i[i] && (!vld_o || age_i[i] > best_age)) begin
        vld_o    = 1'b1;
        idx_o    = IDX_W'(i);
        best_age = age_i[i];
      end
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      if (req_i[i] && !vld_o) begin
        vld_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
`endif
    gnt_o[idx_o] = vld_o;
  end

endmodule

// File: rtl/combo_reservation_station.sv
// Reservation station for the combo (ALU/branch) unit: captures operands from regfile/CDB, issues one ready op per cycle.
// Optional macro RS_AGE_ORDER_EN: oldest-ready issue order instead of lowest-index.
module combo_reservation_station
  import combo_reservation_station_pkg::*;
#(
  parameter int XLEN  = RS_XLEN,
  parameter int DEPTH = RS_DEPTH,
  parameter int REGW  = RS_REGW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            disp_valid,
  output logic            disp_ready,
  input  logic [XLEN-1:0] disp_address,
  input  logic [XLEN-1:0] disp_immediate,
  input  logic [REGW-1:0] disp_src_1,
  input  logic [REGW-1:0] disp_src_2,
  input  logic [REGW-1:0] disp_arn,
  input  logic [REGW-1:0] disp_rrn,
  input  logic            disp_jump,
  input  logic            disp_tag,
  input  instr_name_e     disp_instr_name,
  input  st_type_e        disp_st_type,
  input  logic [XLEN-1:0] src_1_data,
  input  logic            src_1_rdy,
  input  logic [XLEN-1:0] src_2_data,
  input  logic            src_2_rdy,
  input  logic            cdb_valid,
  input  logic [REGW-1:0] cdb_rrn,
  input  logic [XLEN-1:0] cdb_data,
  input  logic            flush,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [XLEN-1:0] issue_address,
  output logic [XLEN-1:0] issue_immediate,
  output logic [XLEN-1:0] issue_op_1,
  output logic [XLEN-1:0] issue_op_2,
  output logic [REGW-1:0] issue_rrn,
  output logic            issue_jump,
  output logic            issue_tag,
  output instr_name_e     issue_instr_name,
  output st_type_e        issue_st_type,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  rs_entry_t              entries_q [DEPTH];
  rs_entry_t              entries_d [DEPTH];
  logic [CNT_W-1:0]       count_q, count_d;
  rs_entry_t              new_entry;
  logic [DEPTH-1:0]       ready_vec, removed, sel_gnt;
  logic [IDX_W-1:0]       sel_idx, free_idx;
  logic                   sel_vld, free_vld, write_en, issue_fire;
`ifdef RS_AGE_ORDER_EN
  logic [DEPTH-1:0][IDX_W-1:0] age_vec;
  logic [IDX_W-1:0]            younger;
`endif

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = entries_q[i].valid & entries_q[i].rdy_1 & entries_q[i].rdy_2;
`ifdef RS_AGE_ORDER_EN
      age_vec[i]   = entries_q[i].age;
`endif
    end
  end

  combo_reservation_station_rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .req_i (ready_vec),
`ifdef RS_AGE_ORDER_EN
    .age_i (age_vec),
`endif
    .gnt_o (sel_gnt),
    .idx_o (sel_idx),
    .vld_o (sel_vld)
  );

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign disp_ready  = ~full;
  assign issue_valid = sel_vld & ~(flush & entries_q[sel_idx].payload.tag);
  assign issue_fire  = issue_valid & issue_ready;

  // Payload is forced to zero whenever nothing is being offered.
  assign issue_address    = issue_valid ? entries_q[sel_idx].payload.address   : '0;
  assign issue_immediate  = issue_valid ? entries_q[sel_idx].payload.immediate : '0;
  assign issue_op_1       = issue_valid ? entries_q[sel_idx].op_1              : '0;
  assign issue_op_2       = issue_valid ? entries_q[sel_idx].op_2              : '0;
  assign issue_rrn        = issue_valid ? entries_q[sel_idx].payload.rrn       : '0;
  assign issue_jump       = issue_valid & entries_q[sel_idx].payload.jump;
  assign issue_tag        = issue_valid & entries_q[sel_idx].payload.tag;
  assign issue_instr_name = issue_valid ? entries_q[sel_idx].payload.instr_name : UNKNOWN;
  assign issue_st_type    = issue_valid ? entries_q[sel_idx].payload.st_type    : ST_NONE;

  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!entries_q[i].valid && !free_vld) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // A wrong-path dispatch arriving during a flush is dropped outright.
  assign write_en = disp_valid & disp_ready & free_vld & ~(flush & disp_tag);

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      removed[i] = entries_q[i].valid & ((flush & entries_q[i].payload.tag) | (issue_fire & sel_gnt[i]));
  end

  always_comb begin
    new_entry                    = '0;
    new_entry.valid              = 1'b1;
    new_entry.payload.address    = disp_address;
    new_entry.payload.immediate  = disp_immediate;
    new_entry.payload.src_1      = disp_src_1;
    new_entry.payload.src_2      = disp_src_2;
    new_entry.payload.arn        = disp_arn;
    new_entry.payload.rrn        = disp_rrn;
    new_entry.payload.jump       = disp_jump;
    new_entry.payload.tag        = disp_tag;
    new_entry.payload.instr_name = disp_instr_name;
    new_entry.payload.st_type    = disp_st_type;
    // A same-cycle CDB hit takes priority over the regfile value.
    if (cdb_valid && cdb_rrn == disp_src_1) begin
      new_entry.op_1  = cdb_data;
      new_entry.rdy_1 = 1'b1;
    end else begin
      new_entry.op_1  = src_1_data;
      new_entry.rdy_1 = src_1_rdy;
    end
    if (cdb_valid && cdb_rrn == disp_src_2) begin
      new_entry.op_2  = cdb_data;
      new_entry.rdy_2 = 1'b1;
    end else begin
      new_entry.op_2  = src_2_data;
      new_entry.rdy_2 = src_2_rdy;
    end
  end

  always_comb begin
    entries_d = entries_q;
`ifdef RS_AGE_ORDER_EN
    younger = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (removed[i]) begin
        entries_d[i].valid = 1'b0;
      end else if (entries_q[i].valid) begin
        if (cdb_valid && !entries_q[i].rdy_1 && entries_q[i].payload.src_1 == cdb_rrn) begin
          entries_d[i].op_1  = cdb_data;
          entries_d[i].rdy_1 = 1'b1;
        end
        if (cdb_valid && !entries_q[i].rdy_2 && entries_q[i].payload.src_2 == cdb_rrn) begin
          entries_d[i].op_2  = cdb_data;
          entries_d[i].rdy_2 = 1'b1;
        end
`ifdef RS_AGE_ORDER_EN
        // Age = number of live younger entries, so it stays below DEPTH.
        younger = '0;
        for (int j = 0; j < DEPTH; j++)
          if (removed[j] && entries_q[j].age < entries_q[i].age) younger = younger + IDX_W'(1);
        entries_d[i].age = entries_q[i].age + IDX_W'(write_en) - younger;
`endif
      end
    end
    if (write_en) entries_d[free_idx] = new_entry;
  end

  assign count_d = count_q + CNT_W'(write_en) - rs_popcount(removed);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_combo_reservation_station.sv
// Self-checking bench: directed scenarios plus randomized traffic against a slot/sequence-number reference model.
module tb_combo_reservation_station;
  import combo_reservation_station_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, disp_valid, disp_ready, disp_jump, disp_tag;
  logic [31:0] disp_address, disp_immediate, src_1_data, src_2_data, cdb_data;
  logic [5:0]  disp_src_1, disp_src_2, disp_arn, disp_rrn, cdb_rrn, issue_rrn;
  instr_name_e disp_instr_name, issue_instr_name;
  st_type_e    disp_st_type, issue_st_type;
  logic        src_1_rdy, src_2_rdy, cdb_valid, flush, issue_valid, issue_ready;
  logic [31:0] issue_address, issue_immediate, issue_op_1, issue_op_2;
  logic        issue_jump, issue_tag, full, empty;

  combo_reservation_station dut (
    .clk(clk), .reset_n(reset_n), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_address(disp_address), .disp_immediate(disp_immediate), .disp_src_1(disp_src_1),
    .disp_src_2(disp_src_2), .disp_arn(disp_arn), .disp_rrn(disp_rrn), .disp_jump(disp_jump),
    .disp_tag(disp_tag), .disp_instr_name(disp_instr_name), .disp_st_type(disp_st_type),
    .src_1_data(src_1_data), .src_1_rdy(src_1_rdy), .src_2_data(src_2_data), .src_2_rdy(src_2_rdy),
    .cdb_valid(cdb_valid), .cdb_rrn(cdb_rrn), .cdb_data(cdb_data), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_address(issue_address),
    .issue_immediate(issue_immediate), .issue_op_1(issue_op_1), .issue_op_2(issue_op_2),
    .issue_rrn(issue_rrn), .issue_jump(issue_jump), .issue_tag(issue_tag),
    .issue_instr_name(issue_instr_name), .issue_st_type(issue_st_type), .full(full), .empty(empty)
  );

  typedef struct {
    bit          v;
    bit [31:0]   addr, imm, o1, o2;
    bit [5:0]    s1, s2, rrn;
    bit          r1, r2, jump, tag;
    instr_name_e name;
    st_type_e    st;
    int          seq;
  } m_t;

  m_t m [8];
  int m_cnt = 0, seq_ctr = 0, tests = 0, failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference selection: lowest slot, or earliest-dispatched when age ordering is built in.
  function automatic int m_sel();
    int s = -1;
    for (int i = 0; i < 8; i++) begin
      if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef RS_AGE_ORDER_EN
        if (s < 0 || m[i].seq < m[s].seq) s = i;
`else
        if (s < 0) s = i;
`endif
      end
    end
    return s;
  endfunction

  task automatic auto_check();
    int s;
    bit ev;
    s  = m_sel();
    ev = (s >= 0) && !(flush && m[s].tag);
    chk("disp_ready", disp_ready, m_cnt < 8);
    chk("full", full, m_cnt == 8);
    chk("empty", empty, m_cnt == 0);
    chk("issue_valid", issue_valid, ev);
    if (ev) begin
      chk("op_1", issue_op_1, m[s].o1);
      chk("op_2", issue_op_2, m[s].o2);
      chk("rrn_addr", {issue_rrn, issue_address}, {m[s].rrn, m[s].addr});
      chk("name", issue_instr_name, m[s].name);
      chk("misc", {issue_immediate, issue_jump, issue_tag, issue_st_type},
          {m[s].imm, m[s].jump, m[s].tag, m[s].st});
    end else begin
      chk("idle_payload", {issue_op_1, issue_op_2}, 64'd0);
      chk("idle_name", issue_instr_name, UNKNOWN);
    end
  endtask

  task automatic model_edge();
    int s, f;
    bit fire, wr;
    bit rm [8];
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m[i].v = 1'b0;
      m_cnt = 0;
      return;
    end
    s    = m_sel();
    fire = (s >= 0) && !(flush && m[s].tag) && issue_ready;
    wr   = disp_valid && (m_cnt < 8) && !(flush && disp_tag);
    f    = -1;
    for (int i = 0; i < 8; i++) if (!m[i].v && f < 0) f = i;
    for (int i = 0; i < 8; i++) rm[i] = m[i].v && ((flush && m[i].tag) || (fire && i == s));
    for (int i = 0; i < 8; i++) begin
      if (m[i].v && !rm[i] && cdb_valid) begin
        if (!m[i].r1 && m[i].s1 == cdb_rrn) begin m[i].o1 = cdb_data; m[i].r1 = 1'b1; end
        if (!m[i].r2 && m[i].s2 == cdb_rrn) begin m[i].o2 = cdb_data; m[i].r2 = 1'b1; end
      end
      if (rm[i]) begin m[i].v = 1'b0; m_cnt--; end
    end
    if (wr) begin
      m[f].v    = 1'b1;
      m[f].addr = disp_address;  m[f].imm = disp_immediate;
      m[f].s1   = disp_src_1;    m[f].s2  = disp_src_2;   m[f].rrn = disp_rrn;
      m[f].jump = disp_jump;     m[f].tag = disp_tag;
      m[f].name = disp_instr_name; m[f].st = disp_st_type;
      m[f].r1   = src_1_rdy || (cdb_valid && cdb_rrn == disp_src_1);
      m[f].o1   = (cdb_valid && cdb_rrn == disp_src_1) ? cdb_data : src_1_data;
      m[f].r2   = src_2_rdy || (cdb_valid && cdb_rrn == disp_src_2);
      m[f].o2   = (cdb_valid && cdb_rrn == disp_src_2) ? cdb_data : src_2_data;
      m[f].seq  = seq_ctr++;
      m_cnt++;
    end
  endtask

  task automatic cycle();
    #1;
    if (chk_en) auto_check();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic put(input bit [5:0] s1, input bit r1, input bit [31:0] d1,
                     input bit [5:0] s2, input bit r2, input bit [31:0] d2, input bit tg);
    disp_valid = 1'b1;
    disp_src_1 = s1; src_1_rdy = r1; src_1_data = d1;
    disp_src_2 = s2; src_2_rdy = r2; src_2_data = d2;
    disp_tag   = tg;
    disp_address    = $urandom;
    disp_immediate  = $urandom;
    disp_rrn        = 6'($urandom);
    disp_arn        = 6'($urandom);
    disp_jump       = 1'($urandom);
    disp_instr_name = instr_name_e'(4'($urandom_range(1, 15)));
    disp_st_type    = st_type_e'(2'($urandom));
  endtask

  int  n_iss;
  bit  seen_9, seen_a;

  initial begin
    reset_n = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0; issue_ready = 1'b1;
    disp_address = '0; disp_immediate = '0; disp_src_1 = '0; disp_src_2 = '0; disp_arn = '0;
    disp_rrn = '0; disp_jump = 1'b0; disp_tag = 1'b0; disp_instr_name = UNKNOWN;
    disp_st_type = ST_NONE; src_1_data = '0; src_2_data = '0; src_1_rdy = 1'b0;
    src_2_rdy = 1'b0; cdb_rrn = '0; cdb_data = '0;
    cycle(); cycle();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    #1;
    chk("rst_issue_valid", issue_valid, 1'b0);
    chk("rst_disp_ready", disp_ready, 1'b1);
    chk("rst_empty_full", {empty, full}, 2'b10);
    chk("rst_name", issue_instr_name, UNKNOWN);

    // 1: fully-ready dispatch issues the next cycle, station empty the cycle after
    put(6'h01, 1, 32'd5, 6'h02, 1, 32'd7, 0);
    cycle();
    #1;
    chk("t1_valid", issue_valid, 1'b1);
    chk("t1_ops", {issue_op_1, issue_op_2}, {32'd5, 32'd7});
    cycle();
    #1;
    chk("t1_empty", empty, 1'b1);

    // 2: operand woken by a later CDB broadcast
    put(6'h01, 1, 32'd3, 6'h12, 0, 32'h0, 0);
    cycle();
    #1;
    chk("t2_wait", issue_valid, 1'b0);
    cycle(); cycle();
    cdb_valid = 1'b1; cdb_rrn = 6'h12; cdb_data = 32'hAB;
    cycle();
    #1;
    chk("t2_valid", issue_valid, 1'b1);
    chk("t2_op_2", issue_op_2, 32'hAB);
    cycle();

    // 3: CDB in the dispatch cycle
    put(6'h20, 0, 32'h11, 6'h21, 1, 32'h1, 0);
    cdb_valid = 1'b1; cdb_rrn = 6'h20; cdb_data = 32'h55;
    cycle();
    #1;
    chk("t3_valid", issue_valid, 1'b1);
    chk("t3_op_1", issue_op_1, 32'h55);
    cycle();

    // 4: fill, overflow dropped, free one, refill
    issue_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      put(6'h01, 1, 32'h100 + k, 6'h02, 1, 32'h0, 0);
      cycle();
    end
    #1;
    chk("t4_full", {full, disp_ready}, 2'b10);
    put(6'h01, 1, 32'h999, 6'h02, 1, 32'h0, 0);
    cycle();
    #1;
    chk("t4_still_full", full, 1'b1);
    chk("t4_head", issue_op_1, 32'h100);
    issue_ready = 1'b1;
    put(6'h01, 1, 32'h999, 6'h02, 1, 32'h0, 0);
    cycle();
    #1;
    chk("t4_freed", {full, disp_ready}, 2'b01);
    issue_ready = 1'b0;
    put(6'h01, 1, 32'hA0A, 6'h02, 1, 32'h0, 0);
    cycle();
    #1;
    chk("t4_refull", full, 1'b1);
    issue_ready = 1'b1;
    seen_9 = 1'b0; seen_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (issue_valid && issue_op_1 == 32'h999) seen_9 = 1'b1;
      if (issue_valid && issue_op_1 == 32'hA0A) seen_a = 1'b1;
      cycle();
    end
    chk("t4_dropped", seen_9, 1'b0);
    chk("t4_refill_issued", seen_a, 1'b1);
    chk("t4_drained", empty, 1'b1);

    // 5: flush keeps only tag==0 entries and drops a tag==1 dispatch in the flush cycle
    issue_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      put(6'h01, 1, 32'h500 + k, 6'h02, 1, 32'h0, k < 4);
      cycle();
    end
    flush = 1'b1;
    put(6'h01, 1, 32'h5FF, 6'h02, 1, 32'h0, 1);
    #1;
    chk("t5_flush_block", issue_valid, 1'b0);
    cycle();
    issue_ready = 1'b1;
    n_iss = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (issue_valid) n_iss++;
      cycle();
    end
    chk("t5_survivors", n_iss, 2);
    chk("t5_empty", empty, 1'b1);

    // 6: slot 3 older than slot 1, both ready
    issue_ready = 1'b0;
    put(6'h30, 0, 32'h0, 6'h02, 1, 32'h600, 0); cycle();
    put(6'h01, 1, 32'h0, 6'h02, 1, 32'h601, 1); cycle();
    put(6'h32, 0, 32'h0, 6'h02, 1, 32'h602, 0); cycle();
    put(6'h33, 0, 32'h0, 6'h02, 1, 32'h603, 0); cycle();
    flush = 1'b1;
    cycle();
    put(6'h01, 1, 32'h0, 6'h02, 1, 32'h611, 0); cycle();
    cdb_valid = 1'b1; cdb_rrn = 6'h33; cdb_data = 32'h33;
    cycle();
    #1;
`ifdef RS_AGE_ORDER_EN
    chk("t6_first", issue_op_2, 32'h603);
`else
    chk("t6_first", issue_op_2, 32'h611);
`endif
    issue_ready = 1'b1;
    cycle();
    #1;
`ifdef RS_AGE_ORDER_EN
    chk("t6_second", issue_op_2, 32'h611);
`else
    chk("t6_second", issue_op_2, 32'h603);
`endif
    cdb_valid = 1'b1; cdb_rrn = 6'h30; cdb_data = 32'h30; cycle();
    cdb_valid = 1'b1; cdb_rrn = 6'h32; cdb_data = 32'h32; cycle();
    for (int k = 0; k < 4; k++) cycle();
    #1;
    chk("t6_empty", empty, 1'b1);

    // mid-operation reset discards everything
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(6'h01, 1, 32'h700 + k, 6'h02, 1, 32'h0, 0);
      cycle();
    end
    reset_n = 1'b0;
    put(6'h01, 1, 32'h7FF, 6'h02, 1, 32'h0, 0);
    cycle();
    reset_n = 1'b1;
    #1;
    chk("mid_rst", {empty, full, disp_ready, issue_valid}, 4'b1010);

    // randomized traffic
    for (int k = 0; k < 800; k++) begin
      reset_n     = ($urandom_range(0, 199) != 0);
      issue_ready = ($urandom_range(0, 3) < ((k < 400) ? 3 : 1));
      flush       = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1)
        put(6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom,
            6'($urandom_range(0, 7)), $urandom_range(0, 2) == 0, $urandom, 1'($urandom));
      cdb_valid = 1'($urandom);
      cdb_rrn   = 6'($urandom_range(0, 7));
      cdb_data  = $urandom;
      cycle();
    end
    reset_n = 1'b1;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
